// File: rtl/aurora_rx_assembler.sv
// aurora_rx_assembler: rebuilds framed MSB-first AXI-Stream beats into tagged FIFO entries.
// Define AURORA_RX_STICKY_ERR_EN to make Error sticky until reset; otherwise it pulses once per error event.
module aurora_rx_assembler #(
    parameter int PACKET_SIZE   = 128,
    parameter int RX_TDATA_SIZE = 32
) (
    input  logic                     user_clk,
    input  logic                     RST,
    input  logic                     start,
    input  logic [RX_TDATA_SIZE-1:0] m_axi_rx_tdata,
    input  logic                     m_axi_rx_tvalid,
    input  logic                     m_axi_rx_tlast,
    output logic [PACKET_SIZE-1:0]   din,
    output logic                     wr_en,
    input  logic                     full,
    output logic                     Error
);
    localparam int P   = PACKET_SIZE - 8;
    localparam int W   = RX_TDATA_SIZE;
    localparam int N   = (P + W - 1) / W;
    localparam int CW  = $clog2(N) + 1;
    localparam int SRW = N * W;

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [SRW-1:0] sr, sr_nxt, sr_shift;
    logic [7:0]     tag;
    logic           wr_nxt, err_evt, at_end;

    // Shift form keeps the single-beat (N == 1) configuration legal.
    assign sr_shift = (sr << W) | SRW'(m_axi_rx_tdata);
    assign at_end   = cnt == CW'(N - 1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sr_nxt    = sr;
        wr_nxt    = 1'b0;
        err_evt   = 1'b0;
        if (!start) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: state_nxt = COLLECT;
                COLLECT: if (m_axi_rx_tvalid) begin
                    sr_nxt = sr_shift;
                    if (m_axi_rx_tlast) begin
                        cnt_nxt = '0;
                        wr_nxt  = at_end && !full;
                        err_evt = !at_end || full;
                    end else if (at_end) begin
                        cnt_nxt   = '0;
                        state_nxt = DISCARD;
                        err_evt   = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                DISCARD: state_nxt = (m_axi_rx_tvalid && m_axi_rx_tlast) ? COLLECT : DISCARD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge user_clk or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            din   <= '0;
            wr_en <= 1'b0;
            tag   <= '0;
            Error <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sr    <= sr_nxt;
            wr_en <= wr_nxt;
            if (wr_nxt) begin
                din <= {tag, sr_shift[SRW-1 -: P]};
                tag <= tag + 8'd1;
            end
`ifdef AURORA_RX_STICKY_ERR_EN
            Error <= Error | err_evt;
`else
            Error <= err_evt;
`endif
        end
    end
endmodule

// File: tb/tb_aurora_rx_assembler.sv
// tb_aurora_rx_assembler: randomized frames checked by a cycle-exact scoreboard of writes and error events.
module tb_aurora_rx_assembler;
    localparam int PS = 128;
    localparam int W  = 32;
    localparam int P  = PS - 8;
    localparam int N  = (P + W - 1) / W;

    typedef struct {
        bit            is_err;
        logic [PS-1:0] d;
        int            cyc;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n, start, tvalid, tlast, full, wr_en, err;
    logic [W-1:0]  tdata;
    logic [PS-1:0] din;

    ev_t  q[$];
    int   total = 0, bad = 0, cyc = 0, cur = 0;
    logic [7:0] tag_m = 8'd0;
    bit   err_any = 1'b0, mon_en = 1'b0, err_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aurora_rx_assembler #(.PACKET_SIZE(PS), .RX_TDATA_SIZE(W)) dut (
        .user_clk(clk), .RST(rst_n), .start(start),
        .m_axi_rx_tdata(tdata), .m_axi_rx_tvalid(tvalid), .m_axi_rx_tlast(tlast),
        .din(din), .wr_en(wr_en), .full(full), .Error(err)
    );

    task automatic check(input string name, input logic [PS-1:0] act, input logic [PS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [W-1:0] d, input logic l, input logic f);
        @(negedge clk);
        tvalid = v;
        tdata  = d;
        tlast  = l;
        full   = f;
        cur    = cyc;
    endtask

    task automatic push_wr(input logic [PS-1:0] d);
        q.push_back('{is_err: 1'b0, d: d, cyc: cur + 1});
    endtask

    task automatic push_err();
`ifdef AURORA_RX_STICKY_ERR_EN
        if (!err_any) q.push_back('{is_err: 1'b1, d: '0, cyc: cur + 1});
`else
        q.push_back('{is_err: 1'b1, d: '0, cyc: cur + 1});
`endif
        err_any = 1'b1;
    endtask

    // A frame is judged only by its valid-beat count and the full flag on its final beat.
    task automatic frame(input int len, input bit f_last, input bit gaps, input int abort_at);
        logic [N*W-1:0] acc;
        logic [W-1:0]   w;
        bit             last;
        int             n;
        acc = '0;
        for (int i = 0; i < len; i++) begin
            if (gaps)
                for (int k = 0; k < 3 && $urandom_range(2) == 0; k++)
                    beat(1'b0, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
            if (i == abort_at) begin
                n = 1 + $urandom_range(1);
                for (int k = 0; k < n; k++) begin
                    beat(1'b1, $urandom, 1'b1, 1'b0);
                    start = 1'b0;
                end
                beat(1'b1, $urandom, 1'b1, 1'b0);
                start = 1'b1;
                return;
            end
            w    = $urandom;
            last = (i == len - 1);
            beat(1'b1, w, last, last ? f_last : 1'($urandom_range(1)));
            if (i < N) acc = (acc << W) | (N*W)'(w);
            if (last && i < N - 1) push_err();
            if (i == N - 1) begin
                if (!last || f_last) push_err();
                else begin
                    push_wr({tag_m, acc[N*W-1 -: P]});
                    tag_m++;
                end
            end
        end
    endtask

    task automatic take(input bit is_err, input logic [PS-1:0] d);
        ev_t e;
        if (q.size() == 0 || q[0].cyc != cyc) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s at cycle %0d: got event, required none (next expected cycle %0d)",
                     is_err ? "error" : "write", cyc, q.size() ? q[0].cyc : -1);
        end else begin
            e = q.pop_front();
            check("event_kind", PS'(is_err), PS'(e.is_err));
            if (!is_err) check("din", d, e.d);
        end
    endtask

    always @(negedge clk) begin
        bit ev_er;
        if (mon_en) begin
`ifdef AURORA_RX_STICKY_ERR_EN
            ev_er = err && !err_prev;
`else
            ev_er = err;
`endif
            err_prev = err;
            if (wr_en) take(1'b0, din);
            if (ev_er) take(1'b1, '0);
            if (q.size() > 0 && q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_%s: got nothing at cycle %0d, required event", q[0].is_err ? "error" : "write", q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int len, ab;
        bit f;
        rst_n = 1'b0; start = 1'b0; tvalid = 1'b0; tlast = 1'b0; full = 1'b0; tdata = '0;
        repeat (3) @(negedge clk);
        check("reset_din", din, '0);
        check("reset_wr_en", PS'(wr_en), '0);
        check("reset_error", PS'(err), '0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) beat(1'b1, $urandom, 1'b1, 1'b0);
        beat(1'b0, '0, 1'b0, 1'b0);
        start = 1'b1;
        beat(1'b1, 32'h01234567, 1'b0, 1'b0);
        beat(1'b1, 32'h89ABCDEF, 1'b0, 1'b0);
        beat(1'b1, 32'h02468ACE, 1'b0, 1'b0);
        beat(1'b1, 32'h13579B00, 1'b1, 1'b0);
        push_wr({8'h00, 120'h0123456789ABCDEF02468ACE13579B});
        tag_m++;
        for (int i = 0; i < 300; i++) frame(N, 1'b0, 1'b0, -1);
        frame(2, 1'b0, 1'b0, -1);
        frame(N, 1'b0, 1'b0, -1);
        frame(6, 1'b0, 1'b0, -1);
        frame(N, 1'b0, 1'b0, -1);
        frame(N, 1'b1, 1'b0, -1);
        frame(N, 1'b0, 1'b0, -1);
        frame(N, 1'b0, 1'b0, 2);
        frame(N, 1'b0, 1'b0, -1);
        for (int i = 0; i < 200; i++) begin
            len = $urandom_range(N + 2, 1);
            f   = $urandom_range(3) == 0;
            ab  = ($urandom_range(9) == 0) ? int'($urandom_range(len - 1)) : -1;
            frame(len, f, 1'b1, ab);
        end
        repeat (5) beat(1'b0, '0, 1'b0, 1'b0);
        check("queue_drained", PS'(q.size()), '0);
`ifdef AURORA_RX_STICKY_ERR_EN
        check("sticky_error_held", PS'(err), PS'(err_any));
`else
        check("error_idle_low", PS'(err), '0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aurora_rx_assembler.md
# aurora_rx_assembler

- Receive-side counterpart of the Aurora TX packet serializer.
- Sits between the Aurora core user RX AXI-Stream port and the RX packet FIFO write port, in the `user_clk` domain.
- Collects the MSB-first words of one framed packet, validates the frame length and writes one PACKET_SIZE-wide entry: 8-bit sequence tag plus payload.
- Malformed frames and FIFO overflows are dropped and flagged on `Error`.

## Interface

Parameters:
- PACKET_SIZE, 128, FIFO entry width; payload width P = PACKET_SIZE-8.
- RX_TDATA_SIZE, 32, AXI-Stream data width W.
- Derived: N = ceil(P/W) beats per frame (4 at defaults); beat counter width = clog2(N)+1.

Ports:
- user_clk  in  1  Aurora user clock; all logic on rising edge.
- RST  in  1  asynchronous, active-low reset.
- start  in  1  link-ready from the Aurora init sequencer; level, synchronous to user_clk.
- m_axi_rx_tdata  in  W  received word; bit W-1 is the first payload bit on the wire.
- m_axi_rx_tvalid  in  1  beat valid. There is no tready: every valid beat is consumed.
- m_axi_rx_tlast  in  1  last beat of frame.
- din  out  PACKET_SIZE  FIFO write data: {tag[7:0], payload[P-1:0]}.
- wr_en  out  1  FIFO write strobe, one cycle per packet.
- full  in  1  FIFO full.
- Error  out  1  error indication (see Configuration).

## Operation

States:
- IDLE
  - Entered on reset and whenever start = 0. Beats are ignored.
  - Goes to COLLECT when start = 1.
- COLLECT
  - Each valid beat shifts the word into an N*W-bit shift register: sr <= {sr[N*W-W-1:0], tdata}. The beat counter increments.
  - Valid beat with tlast, count == N-1: frame good.
    - If full = 0 in that cycle: load din and pulse wr_en. Payload = sr_next[N*W-1 -: P], left-justified; the zero pad bits in the low end of the last word are discarded.
    - If full = 1: drop the frame and raise the error event.
    - Either way, clear the counter and stay in COLLECT.
  - Valid beat with tlast, count < N-1 (short frame): drop, raise the error event, clear the counter.
  - Valid beat without tlast, count == N-1 (long frame): drop, raise the error event, go to DISCARD.
- DISCARD
  - Ignore beats until a valid beat with tlast, then clear the counter and return to COLLECT.
  - Frames after the discarded one are handled normally.

Rules applying in all states:
- start falling in COLLECT or DISCARD: go to IDLE immediately, clear the counter, no write, no error.
- tvalid = 0 beats are ignored, including gaps inside a frame.

Sequence tag:
- tag is an 8-bit counter.
- Incremented only on a successful write; wraps 255 -> 0.
- Dropped frames do not advance it. The first packet after reset carries tag 0.

## Timing

Reset values:
- din = 0, wr_en = 0, Error = 0, tag = 0, counter = 0, state = IDLE.

Write latency:
- wr_en and din are registered.
- wr_en is high for exactly the cycle after the accepted final beat. din is valid in that same cycle.

Back-to-back frames:
- The first beat of the next frame may arrive in the cycle wr_en is high.
- Sustained 100% tvalid throughput is supported; no beats are lost.

full:
- full is sampled only in the final-beat cycle.
- full changing in the wr_en cycle does not retract the write.

Error event:
- Occurs in the cycle after the offending beat, with the same latency as wr_en.

## Configuration

- AURORA_RX_STICKY_ERR_EN defined:
  - Error is sticky: set on the first error event and held until RST.
  - start falling does not clear it.
- Not defined:
  - Error is a one-cycle pulse per error event.
  - Coincident events produce a single pulse.

## Test plan

- Reset, start = 1, one good frame (defaults), words 0x01234567, 0x89ABCDEF, 0x02468ACE, 0x13579B00 with tlast on beat 4 -> one wr_en, din = {8'h00, 120'h0123456789ABCDEF02468ACE13579B}, Error = 0.
- 300 back-to-back good frames with continuous tvalid -> 300 wr_en pulses, tag sequence 0..255 then 0..43, no Error.
- Short frame (tlast on beat 2), then a good frame -> no write for the short frame, Error event one cycle after beat 2; the good frame is written with tag 0.
- Long frame (6 beats, tlast on beat 6), then a good frame -> Error one cycle after beat 4, no write for the long frame; the good frame is written normally.
- full = 1 during the final beat -> no wr_en, Error event, tag not advanced; next frame with full = 0 is written with the unchanged tag.
- start dropped after beat 2, raised again, then a fresh good frame -> no write and no Error for the aborted frame; the fresh frame is written correctly.
- Run the full suite once with and once without AURORA_RX_STICKY_ERR_EN -> Error behaviour matches Configuration in both builds.
